// File: rtl/trig_detect.sv
// Edge trigger detector with hysteresis and a pre-trigger guard.
// An acquisition starts on arm; the first PRE_SAMPLES valid samples only
// establish the signal zone, after which a LOW->HIGH (rise) or HIGH->LOW
// (fall) zone crossing fires a single trigger and records the sample index.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for arm; counter and zone cleared
// ST_PRE   | counting guard samples, zone tracked, no trigger possible
// ST_ARMED | zone tracked, first enabled crossing fires the trigger
// ST_TRIG  | trigger captured and held until arm is released
module trig_detect #(
    parameter int PRE_SAMPLES = 512,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [7:0]       sample,
    input  logic             sample_valid,
    input  logic             en_rise,
    input  logic             en_fall,
    input  logic [7:0]       lower_bound,
    input  logic [7:0]       upper_bound,
    output logic             armed,
    output logic             triggered,
    output logic             trig_pulse,
    output logic             trig_edge,
    output logic [CNT_W-1:0] trig_index
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_ARMED = 2'd2,
        ST_TRIG  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ZN_UNKNOWN = 2'd0,
        ZN_LOW     = 2'd1,
        ZN_HIGH    = 2'd2
    } zone_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] PRE_LAST =
        (PRE_SAMPLES == 0) ? '0 : CNT_W'(PRE_SAMPLES - 1);

    state_t           state_q;
    zone_t            zone_q;
    zone_t            zone_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             armed_q;
    logic             triggered_q;
    logic             trig_pulse_q;
    logic             trig_edge_q;
    logic [CNT_W-1:0] trig_index_q;

    logic [7:0]       thr_lo;
    logic [7:0]       thr_hi;
    logic             smp_high;
    logic             smp_low;
    logic             rise_ok;
    logic             rise_evt;
    logic             fall_evt;

    // Sample classification against live, order-independent thresholds,
    // plus the zone and counter values a tracked sample would produce.
    always_comb begin
        thr_lo   = (lower_bound <= upper_bound) ? lower_bound : upper_bound;
        thr_hi   = (lower_bound <= upper_bound) ? upper_bound : lower_bound;
        smp_high = sample > thr_hi;
        smp_low  = sample <= thr_lo;
        // With both enables cleared the detector falls back to rising edges.
        rise_ok  = en_rise | ~en_fall;
        rise_evt = rise_ok && (zone_q == ZN_LOW) && smp_high;
        fall_evt = en_fall && (zone_q == ZN_HIGH) && smp_low;

        zone_d = zone_q;
        if (smp_high) begin
            zone_d = ZN_HIGH;
        end else if (smp_low) begin
            zone_d = ZN_LOW;
        end

        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Acquisition FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            zone_q       <= ZN_UNKNOWN;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            triggered_q  <= 1'b0;
            trig_pulse_q <= 1'b0;
            trig_edge_q  <= 1'b0;
            trig_index_q <= '0;
        end else begin
            trig_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q       <= '0;
                    zone_q      <= ZN_UNKNOWN;
                    triggered_q <= 1'b0;
                    if (arm) begin
                        if (PRE_SAMPLES == 0) begin
                            state_q <= ST_ARMED;
                            armed_q <= 1'b1;
                        end else begin
                            state_q <= ST_PRE;
                        end
                    end
                end

                ST_PRE: begin
                    if (!arm) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        zone_q  <= ZN_UNKNOWN;
                    end else if (sample_valid) begin
                        zone_q <= zone_d;
                        cnt_q  <= cnt_d;
                        if (cnt_q == PRE_LAST) begin
                            state_q <= ST_ARMED;
                            armed_q <= 1'b1;
                        end
                    end
                end

                ST_ARMED: begin
                    // Abort has priority over a crossing in the same cycle.
                    if (!arm) begin
                        state_q <= ST_IDLE;
                        armed_q <= 1'b0;
                        cnt_q   <= '0;
                        zone_q  <= ZN_UNKNOWN;
                    end else if (sample_valid) begin
                        if (rise_evt || fall_evt) begin
                            state_q      <= ST_TRIG;
                            armed_q      <= 1'b0;
                            triggered_q  <= 1'b1;
                            trig_pulse_q <= 1'b1;
                            trig_edge_q  <= rise_evt;
                            trig_index_q <= cnt_q;
                        end else begin
                            zone_q <= zone_d;
                            cnt_q  <= cnt_d;
                        end
                    end
                end

                ST_TRIG: begin
                    if (!arm) begin
                        state_q     <= ST_IDLE;
                        triggered_q <= 1'b0;
                        cnt_q       <= '0;
                        zone_q      <= ZN_UNKNOWN;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    armed_q     <= 1'b0;
                    triggered_q <= 1'b0;
                end
            endcase
        end
    end

    assign armed      = armed_q;
    assign triggered  = triggered_q;
    assign trig_pulse = trig_pulse_q;
    assign trig_edge  = trig_edge_q;
    assign trig_index = trig_index_q;

endmodule

// File: doc/trig_detect.md
TRIG_DETECT -- requirements
Module: trig_detect

Interface
REQ-001 SHALL have parameter PRE_SAMPLES, default 512: valid samples accepted after arm before any trigger may fire; range 0..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 16: width of the sample counter and trig_index.
REQ-003 SHALL have port clk, input, 1: single clock, all state on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port arm, input, 1: level request; high starts an acquisition, low aborts or releases it.
REQ-006 SHALL have port sample, input, 8: unsigned ADC sample.
REQ-007 SHALL have port sample_valid, input, 1: sample qualifier; one sample per high cycle.
REQ-008 SHALL have ports en_rise and en_fall, inputs, 1 each: edge enables from the trigger configuration block.
REQ-009 SHALL have ports lower_bound and upper_bound, inputs, 8 each: hysteresis thresholds from the trigger configuration block.
REQ-010 SHALL have port armed, output, 1: high while in ST_ARMED.
REQ-011 SHALL have port triggered, output, 1: level, high while in ST_TRIG.
REQ-012 SHALL have port trig_pulse, output, 1: one-cycle strobe on trigger.
REQ-013 SHALL have port trig_edge, output, 1: 1 = rising, 0 = falling; valid while triggered.
REQ-014 SHALL have port trig_index, output, CNT_W: 0-based index, counted from arm, of the triggering sample.

Function
REQ-015 SHALL use states ST_IDLE, ST_PRE, ST_ARMED, ST_TRIG; encoding free.
REQ-016 SHALL use effective thresholds lo = min(lower_bound, upper_bound) and hi = max(lower_bound, upper_bound); bounds are sampled live every cycle.
REQ-017 SHALL classify a valid sample as HIGH if sample > hi, LOW if sample <= lo, otherwise MID; comparisons unsigned.
REQ-018 SHALL keep a zone register (UNKNOWN/LOW/HIGH); it updates only on a valid sample in ST_PRE or ST_ARMED; MID leaves it unchanged.
REQ-019 SHALL handle ST_IDLE: cnt = 0, zone = UNKNOWN; on arm high go to ST_PRE, or to ST_ARMED if PRE_SAMPLES = 0.
REQ-020 SHALL handle ST_PRE: each valid sample updates the zone and increments cnt; on the edge accepting sample index PRE_SAMPLES-1, go to ST_ARMED; samples in ST_PRE never trigger.
REQ-021 SHALL fire a rise event in ST_ARMED when en_rise = 1, zone = LOW and the sample is HIGH.
REQ-022 SHALL fire a fall event in ST_ARMED when en_fall = 1, zone = HIGH and the sample is LOW.
REQ-023 SHALL treat en_rise = en_fall = 0 as rise-only.
REQ-024 SHALL, on an event, register on the same edge: state = ST_TRIG, trig_pulse = 1 for exactly one cycle, trig_edge, trig_index = cnt; output latency is one clock from the sampled valid.
REQ-025 SHALL have ST_TRIG ignore samples, hold trig_edge and trig_index, and go to ST_IDLE when arm is low.
REQ-026 SHALL, when arm is low in ST_PRE or ST_ARMED, go to ST_IDLE on the next edge; abort beats a same-cycle event (no pulse).
REQ-027 SHALL saturate cnt at 2^CNT_W-1 (no wrap); triggering remains possible and trig_index reports the saturated value.
REQ-028 SHALL accept a re-arm in ST_IDLE, starting with cnt = 0 and zone = UNKNOWN; no trigger fires until the zone is established.
REQ-029 SHALL drive all outputs directly from registers.

Reset
REQ-030 SHALL, on rst low, asynchronously force state = ST_IDLE, zone = UNKNOWN, cnt = 0, armed = 0, triggered = 0, trig_pulse = 0, trig_edge = 0, trig_index = 0.
REQ-031 SHALL abandon any acquisition when reset is asserted mid-operation; after release it waits for a fresh arm edge-level in ST_IDLE.

Verification (PRE_SAMPLES = 4, CNT_W = 16)
REQ-032 SHALL cover rise-edge trigger: en_rise=1, bounds 100/150, arm, samples 10,20,30,40,50,200 -> armed after 4th sample, trig_pulse 1 cycle after 200, trig_edge=1, trig_index=5.
REQ-033 SHALL cover hysteresis: en_rise=1, bounds 100/150, samples 90 x4 then 120,99,130,151 -> no trigger on 120/130, trigger on 151, trig_index=7.
REQ-034 SHALL cover fall and both edges: en_fall=1, en_rise=1, samples 200 x4 then 50 -> trig_edge=0, trig_index=4.
REQ-035 SHALL cover pre-trigger guard: samples 10,200,10,200,10,200 -> no trigger at indices 1 or 3, trigger at index 5.
REQ-036 SHALL cover abort: in ST_ARMED deassert arm in the same cycle as a crossing sample -> no trig_pulse, ST_IDLE next cycle; re-arm -> cnt restarts at 0.
REQ-037 SHALL cover async reset: assert rst low mid-clock during ST_TRIG -> all outputs 0 immediately, without waiting for a clock edge.
